mc_ctrl: RTL and testbench

//  Multi-cycle main controller FSM for the multi-cycle CPU datapath. It sequences FETCH/DECODE/EXEC/MEM/WB,

---
 rtl/mc_ctrl_pkg.sv | 90 +++++++++
 rtl/mc_decode.sv | 71 +++++++
 rtl/mc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, datapath selects,
// error codes and the decoder's instruction-class payload.
package mc_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MC_IDLE   = 3'd0,
    MC_FETCH  = 3'd1,
    MC_DECODE = 3'd2,
    MC_EXEC   = 3'd3,
    MC_MEM    = 3'd4,
    MC_WB     = 3'd5,
    MC_ERR    = 3'd7
  } mc_state_e;

  localparam logic [2:0] PCSRC_PC4 = 3'd0;
  localparam logic [2:0] PCSRC_BR  = 3'd1;
  localparam logic [2:0] PCSRC_J   = 3'd2;
  localparam logic [2:0] PCSRC_JR  = 3'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_LUI = 2'd2;
  localparam logic [1:0] WDSEL_PC  = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [2:0] DMTYPE_W  = 3'd0;
  localparam logic [2:0] DMTYPE_H  = 3'd1;
  localparam logic [2:0] DMTYPE_HU = 3'd2;
  localparam logic [2:0] DMTYPE_B  = 3'd3;
  localparam logic [2:0] DMTYPE_BU = 3'd4;

  localparam logic [1:0] BR_EQ  = 2'd0;
  localparam logic [1:0] BR_NE  = 2'd1;
  localparam logic [1:0] BR_GTZ = 2'd2;
  localparam logic [1:0] BR_LTZ = 2'd3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  typedef struct packed {
    logic       is_rtype;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_jreg;
    logic       is_link;
    logic       is_lui;
    logic       illegal;
    logic [1:0] br_type;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic [2:0] dm_type;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier feeding the controller FSM with
// instruction-class flags and the per-instruction ALU/EXT/DM controls.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_t            dec
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign rt            = instr[20:16];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    dec = '0;
    case (op)
      OP_SPECIAL: begin
        dec.is_rtype = 1'b1;
        case (funct)
          FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUBU: dec.alu_op = ALU_SUB;
          FN_JR:   begin dec.is_jump = 1'b1; dec.is_jreg = 1'b1; end
          FN_JALR: begin dec.is_jump = 1'b1; dec.is_jreg = 1'b1; dec.is_link = 1'b1; end
          default: begin dec.is_rtype = 1'b0; dec.illegal = 1'b1; end
        endcase
      end
      OP_ORI:  begin dec.alu_op = ALU_OR; dec.alu_src = 1'b1; end
      OP_LW:   begin dec.is_load = 1'b1;  dec.dm_type = DMTYPE_W;  end
      OP_LH:   begin dec.is_load = 1'b1;  dec.dm_type = DMTYPE_H;  end
      OP_LHU:  begin dec.is_load = 1'b1;  dec.dm_type = DMTYPE_HU; end
      OP_LB:   begin dec.is_load = 1'b1;  dec.dm_type = DMTYPE_B;  end
      OP_LBU:  begin dec.is_load = 1'b1;  dec.dm_type = DMTYPE_BU; end
      OP_SW:   begin dec.is_store = 1'b1; dec.dm_type = DMTYPE_W;  end
      OP_SH:   begin dec.is_store = 1'b1; dec.dm_type = DMTYPE_H;  end
      OP_SB:   begin dec.is_store = 1'b1; dec.dm_type = DMTYPE_B;  end
      OP_BEQ:  begin dec.is_branch = 1'b1; dec.br_type = BR_EQ;  end
      OP_BNE:  begin dec.is_branch = 1'b1; dec.br_type = BR_NE;  end
      OP_BGTZ: begin dec.is_branch = 1'b1; dec.br_type = BR_GTZ; end
      OP_REGIMM: begin
        // Only bltz (rt == 0) is implemented from the REGIMM group.
        if (rt == 5'd0) begin
          dec.is_branch = 1'b1;
          dec.br_type   = BR_LTZ;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI:  dec.is_lui = 1'b1;
      OP_J:    dec.is_jump = 1'b1;
      OP_JAL:  begin dec.is_jump = 1'b1; dec.is_link = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase

    // Address generation for memory ops is base + sign-extended offset.
    if (dec.is_load || dec.is_store) begin
      dec.alu_op  = ALU_ADD;
      dec.alu_src = 1'b1;
      dec.ext_op  = 1'b1;
    end
    if (dec.is_branch) begin
      dec.ext_op = 1'b1;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU main controller: sequences FETCH/DECODE/EXEC/MEM/WB with a
// wait-state memory handshake, watchdog timeout and sticky error reporting.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned WDT_CYCLES    = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr,
  input  logic            cmp_eq,
  input  logic            rs_gtz,
  input  logic            rs_ltz,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            ir_we,
  output logic            pc_we,
  output logic [2:0]      pc_src,
  output logic            reg_we,
  output logic [1:0]      reg_dst,
  output logic [1:0]      wd_sel,
  output logic [2:0]      alu_op,
  output logic            alu_src,
  output logic            ext_op,
  output logic [2:0]      dm_type,
  output logic [2:0]      state,
  output logic [1:0]      err_code
);

  localparam int unsigned CNT_W = $clog2(WDT_CYCLES + 1);

  mc_state_e        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       err_q, err_n;
  dec_t             dec;
  logic             ready;
  logic             wdt_hit;
  logic             br_taken;

  mc_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  assign ready    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  // Last permitted wait cycle: a ready here still completes the access.
  assign wdt_hit  = (cnt_q == CNT_W'(WDT_CYCLES - 1));
  assign state    = state_q;
  assign err_code = err_q;

  always_comb begin
    case (dec.br_type)
      BR_EQ:   br_taken = cmp_eq;
      BR_NE:   br_taken = ~cmp_eq;
      BR_GTZ:  br_taken = rs_gtz;
      default: br_taken = rs_ltz;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = '0;
    err_n   = err_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = PCSRC_PC4;
    reg_we  = 1'b0;
    reg_dst = REGDST_RT;
    wd_sel  = WDSEL_ALU;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    dm_type = DMTYPE_W;

    case (state_q)
      MC_IDLE: state_n = MC_FETCH;

      MC_FETCH: begin
        mem_req = 1'b1;
        if (ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = MC_DECODE;
        end else if (wdt_hit) begin
          state_n = MC_ERR;
          err_n   = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      MC_DECODE: begin
        if (dec.illegal) begin
          state_n = MC_ERR;
          err_n   = ERR_ILLEGAL;
        end else if (dec.is_jump) begin
          pc_we  = 1'b1;
          pc_src = dec.is_jreg ? PCSRC_JR : PCSRC_J;
          if (dec.is_link) begin
            reg_we  = 1'b1;
            reg_dst = dec.is_jreg ? REGDST_RD : REGDST_RA;
            wd_sel  = WDSEL_PC;
          end
          state_n = MC_FETCH;
        end else if (dec.is_lui) begin
          state_n = MC_WB;
        end else begin
          state_n = MC_EXEC;
        end
      end

      MC_EXEC: begin
        alu_op  = dec.alu_op;
        alu_src = dec.alu_src;
        ext_op  = dec.ext_op;
        if (dec.is_branch) begin
          pc_src  = PCSRC_BR;
          pc_we   = br_taken;
          state_n = MC_FETCH;
        end else if (dec.is_load || dec.is_store) begin
          state_n = MC_MEM;
        end else begin
          state_n = MC_WB;
        end
      end

      MC_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec.is_store;
        dm_type = dec.dm_type;
        if (ready) begin
          state_n = dec.is_store ? MC_FETCH : MC_WB;
        end else if (wdt_hit) begin
          state_n = MC_ERR;
          err_n   = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      MC_WB: begin
        reg_we  = 1'b1;
        reg_dst = dec.is_rtype ? REGDST_RD : REGDST_RT;
        wd_sel  = dec.is_load ? WDSEL_MEM : (dec.is_lui ? WDSEL_LUI : WDSEL_ALU);
        state_n = MC_FETCH;
      end

      default: state_n = MC_ERR;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected output traces are built from the
// instruction class, wait-states and compare flags, then replayed cycle by cycle.
module tb_mc_ctrl;

  localparam int WDT = 255;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd7;

  typedef enum int {
    K_ADDU, K_SUBU, K_ORI, K_LW, K_LB, K_LBU, K_LH, K_LHU, K_SW, K_SB,
    K_SH, K_BEQ, K_BNE, K_BGTZ, K_BLTZ, K_LUI, K_J, K_JAL, K_JR, K_JALR, K_ILL
  } kind_e;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [2:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic [2:0] dm_type;
    logic [1:0] err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        cmp_eq, rs_gtz, rs_ltz, mem_ready;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, alu_src, ext_op;
  logic [2:0]  pc_src, alu_op, dm_type, state;
  logic [1:0]  reg_dst, wd_sel, err_code;

  exp_t        obs;
  exp_t        eq[$];
  logic        rq[$];
  logic [1:0]  err_m;
  int          total = 0;
  int          bad   = 0;

  mc_ctrl #(.MEM_HANDSHAKE(1), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .reset(reset), .instr(instr), .cmp_eq(cmp_eq), .rs_gtz(rs_gtz),
    .rs_ltz(rs_ltz), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_op(alu_op), .alu_src(alu_src), .ext_op(ext_op),
    .dm_type(dm_type), .state(state), .err_code(err_code)
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
                wd_sel, alu_op, alu_src, ext_op, dm_type, err_code};

  function automatic logic rnd();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic logic [31:0] enc(input kind_e k);
    logic [31:0] w;
    w = $urandom;
    case (k)
      K_ADDU: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      K_SUBU: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
      K_JR:   begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      K_JALR: begin w[31:26] = 6'h00; w[5:0] = 6'h09; end
      K_ORI:  w[31:26] = 6'h0D;
      K_LW:   w[31:26] = 6'h23;
      K_LB:   w[31:26] = 6'h20;
      K_LBU:  w[31:26] = 6'h24;
      K_LH:   w[31:26] = 6'h21;
      K_LHU:  w[31:26] = 6'h25;
      K_SW:   w[31:26] = 6'h2B;
      K_SB:   w[31:26] = 6'h28;
      K_SH:   w[31:26] = 6'h29;
      K_BEQ:  w[31:26] = 6'h04;
      K_BNE:  w[31:26] = 6'h05;
      K_BGTZ: w[31:26] = 6'h07;
      K_BLTZ: begin w[31:26] = 6'h01; w[20:16] = 5'd0; end
      K_LUI:  w[31:26] = 6'h0F;
      K_J:    w[31:26] = 6'h02;
      K_JAL:  w[31:26] = 6'h03;
      default: w[31:26] = 6'h3F;
    endcase
    return w;
  endfunction

  task automatic push(input exp_t e, input logic r);
    e.err = err_m;
    eq.push_back(e);
    rq.push_back(r);
  endtask

  task automatic add_err(input int n);
    exp_t e;
    e = '0;
    e.st = S_ERR;
    for (int i = 0; i < n; i++) push(e, rnd());
  endtask

  // Expected trace of one instruction: fw/mw are wait cycles before mem_ready.
  task automatic add_instr(input kind_e k, input int fw, input int mw,
                           input logic f_eq, input logic f_gtz, input logic f_ltz);
    exp_t e;
    logic is_ld, is_st, is_br;
    is_ld = k inside {K_LW, K_LB, K_LBU, K_LH, K_LHU};
    is_st = k inside {K_SW, K_SB, K_SH};
    is_br = k inside {K_BEQ, K_BNE, K_BGTZ, K_BLTZ};

    e = '0; e.st = S_FETCH; e.mem_req = 1'b1;
    for (int i = 0; i < fw && i < WDT; i++) push(e, 1'b0);
    if (fw >= WDT) begin err_m = 2'd2; add_err(5); return; end
    e.ir_we = 1'b1; e.pc_we = 1'b1; push(e, 1'b1);

    e = '0; e.st = S_DECODE;
    if (k == K_ILL) begin push(e, rnd()); err_m = 2'd1; add_err(20); return; end
    if (k inside {K_J, K_JAL, K_JR, K_JALR}) begin
      e.pc_we  = 1'b1;
      e.pc_src = (k == K_JR || k == K_JALR) ? 3'd3 : 3'd2;
      if (k == K_JAL)  begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd3; end
      if (k == K_JALR) begin e.reg_we = 1'b1; e.reg_dst = 2'd1; e.wd_sel = 2'd3; end
      push(e, rnd());
      return;
    end
    push(e, rnd());

    if (k != K_LUI) begin
      e = '0; e.st = S_EXEC;
      if (k == K_SUBU) e.alu_op = 3'd1;
      if (k == K_ORI) begin e.alu_op = 3'd2; e.alu_src = 1'b1; end
      if (is_ld || is_st) begin e.alu_src = 1'b1; e.ext_op = 1'b1; end
      if (is_br) begin
        e.ext_op = 1'b1;
        e.pc_src = 3'd1;
        case (k)
          K_BEQ:   e.pc_we = f_eq;
          K_BNE:   e.pc_we = !f_eq;
          K_BGTZ:  e.pc_we = f_gtz;
          default: e.pc_we = f_ltz;
        endcase
        push(e, rnd());
        return;
      end
      push(e, rnd());
      if (is_ld || is_st) begin
        e = '0; e.st = S_MEM; e.mem_req = 1'b1; e.mem_we = is_st;
        case (k)
          K_LH, K_SH: e.dm_type = 3'd1;
          K_LHU:      e.dm_type = 3'd2;
          K_LB, K_SB: e.dm_type = 3'd3;
          K_LBU:      e.dm_type = 3'd4;
          default:    e.dm_type = 3'd0;
        endcase
        for (int i = 0; i < mw; i++) push(e, 1'b0);
        push(e, 1'b1);
        if (is_st) return;
      end
    end

    e = '0; e.st = S_WB; e.reg_we = 1'b1;
    e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    e.wd_sel  = is_ld ? 2'd1 : ((k == K_LUI) ? 2'd2 : 2'd0);
    push(e, rnd());
  endtask

  // Replays up to n queued cycles (n < 0: all); entered and left at posedge+1.
  task automatic play(input string tag, input int n);
    exp_t e;
    int   c;
    c = 0;
    while (eq.size() > 0 && c != n) begin
      e = eq.pop_front();
      mem_ready = rq.pop_front();
      @(negedge clk);
      total++;
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, c, obs, e);
      end
      c++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset(input string tag);
    exp_t e;
    reset = 1'b0;
    #1;
    total++;
    assert (obs === '0) else begin
      bad++;
      $error("FAIL %s obs=%h exp=0", tag, obs);
    end
    eq.delete();
    rq.delete();
    err_m = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    e = '0;
    e.st = S_IDLE;
    push(e, rnd());
  endtask

  task automatic run(input kind_e k, input logic [31:0] w, input int fw, input int mw,
                     input logic f_eq, input logic f_gtz, input logic f_ltz,
                     input string tag);
    instr  = w;
    cmp_eq = f_eq;
    rs_gtz = f_gtz;
    rs_ltz = f_ltz;
    add_instr(k, fw, mw, f_eq, f_gtz, f_ltz);
    play(tag, -1);
  endtask

  initial begin
    kind_e k;
    reset = 1'b1; instr = '0; cmp_eq = 1'b0; rs_gtz = 1'b0; rs_ltz = 1'b0;
    mem_ready = 1'b0; err_m = 2'd0;
    #2;
    chk_reset("reset_init");

    // Stop a load while MEM is still waiting, then re-reset asynchronously.
    instr = 32'h8C220004;
    add_instr(K_LW, 0, 5, 1'b0, 1'b0, 1'b0);
    play("pre_reset", 6);
    chk_reset("reset_mid_mem");

    run(K_ADDU, 32'h00221821, 3, 0, 1'b0, 1'b0, 1'b0, "fetch_wait3");
    run(K_ADDU, 32'h00221821, 0, 0, 1'b0, 1'b0, 1'b0, "addu");
    run(K_LW,   32'h8C220004, 0, 2, 1'b0, 1'b0, 1'b0, "lw_wait2");
    run(K_SB,   32'hA0220001, 0, 0, 1'b0, 1'b0, 1'b0, "sb");
    run(K_BEQ,  32'h10220003, 0, 0, 1'b1, 1'b0, 1'b0, "beq_taken");
    run(K_BEQ,  32'h10220003, 0, 0, 1'b0, 1'b0, 1'b0, "beq_not");
    run(K_BLTZ, 32'h04200002, 0, 0, 1'b0, 1'b0, 1'b1, "bltz_taken");
    run(K_JAL,  32'h0C000C00, 0, 0, 1'b0, 1'b0, 1'b0, "jal");
    run(K_JR,   32'h03E00008, 0, 0, 1'b0, 1'b0, 1'b0, "jr");

    for (int n = 0; n < 60; n++) begin
      k = kind_e'($urandom_range(0, 19));
      run(k, enc(k), $urandom_range(0, 3), $urandom_range(0, 3),
          rnd(), rnd(), rnd(), "rand");
    end

    run(K_ILL, 32'hFC000000, 0, 0, 1'b0, 1'b0, 1'b0, "illegal");
    chk_reset("reset_after_ill");
    run(K_ADDU, 32'h00221821, WDT, 0, 1'b0, 1'b0, 1'b0, "fetch_timeout");
    chk_reset("reset_after_to");
    run(K_ADDU, 32'h00221821, WDT - 1, 0, 1'b0, 1'b0, 1'b0, "fetch_limit_ready");
    run(K_LW,   32'h8C220004, 0, WDT - 1, 1'b0, 1'b0, 1'b0, "mem_limit_ready");
    run(K_ORI,  enc(K_ORI), 1, 0, 1'b0, 1'b0, 1'b0, "ori_after_limit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
